// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry fetch-to-decode FIFO with pre-decoded attributes
// (branch, delay-slot membership, memory class, undefined) computed at push time.
module decode_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter bit          DELAY_SLOT_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [31:0]                  in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_inst,
    output logic [31:0]                  out_pc,
    output logic                         out_in_delay_slot,
    output logic                         out_is_branch,
    output logic                         out_undefined,
    output logic [1:0]                   out_mem_type,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] MEM_NOOP = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] MEM_STOR = 2'd2;

    // Attribute word layout: {in_delay_slot, is_branch, undefined, mem_type[1:0]}
    localparam int unsigned AW = 5;

    logic [31:0]    r_inst [DEPTH];
    logic [31:0]    r_pc   [DEPTH];
    logic [AW-1:0]  r_attr [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_last_was_branch;

    logic [5:0]     w_op;
    logic [4:0]     w_rs;
    logic [4:0]     w_rt;
    logic [5:0]     w_funct;
    logic           w_special_ok;
    logic           w_regimm_ok;
    logic           w_is_branch;
    logic           w_undefined;
    logic [1:0]     w_mem_type;
    logic           w_push;
    logic           w_pop;
    logic [AW-1:0]  w_attr_in;
    logic [AW-1:0]  w_attr_out;

    assign w_op    = in_inst[31:26];
    assign w_rs    = in_inst[25:21];
    assign w_rt    = in_inst[20:16];
    assign w_funct = in_inst[5:0];

    assign in_ready  = (r_count < CW'(DEPTH)) && !flush && !rst;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Pre-decode of the instruction presented at the input
    always_comb begin
        w_special_ok = 1'b0;
        w_regimm_ok  = (w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                       (w_rt == 5'b10000) || (w_rt == 5'b10001);
        w_is_branch  = 1'b0;
        w_undefined  = 1'b1;
        w_mem_type   = MEM_NOOP;

        case (w_funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
            6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: w_special_ok = 1'b1;
            default:                    w_special_ok = 1'b0;
        endcase

        case (w_op)
            6'b000000: begin
                w_undefined = !w_special_ok;
                w_is_branch = (w_funct == 6'b001000) || (w_funct == 6'b001001);
            end
            6'b000001: begin
                w_undefined = !w_regimm_ok;
                w_is_branch = w_regimm_ok;
            end
            6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                w_undefined = 1'b0;
                w_is_branch = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                w_undefined = 1'b0;
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                w_undefined = 1'b0;
                w_mem_type  = MEM_LOAD;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                w_undefined = 1'b0;
                w_mem_type  = MEM_STOR;
            end
            6'b010000: begin
                w_undefined = !((in_inst == 32'h4200_0018) ||
                                (w_rs == 5'b00000) || (w_rs == 5'b00100));
            end
            default: begin
                w_undefined = 1'b1;
            end
        endcase
    end

    assign w_attr_in = {DELAY_SLOT_EN && r_last_was_branch, w_is_branch,
                        w_undefined, w_mem_type};

    // Entry storage; written only on an accepted push (never during rst/flush)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr_ptr] <= in_inst;
            r_pc[r_wr_ptr]   <= in_pc;
            r_attr[r_wr_ptr] <= w_attr_in;
        end
    end

    // Pointers, occupancy and branch tracking; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            r_last_was_branch <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PW'(1);
                r_last_was_branch <= w_is_branch;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view; forced to zero while empty so stale entries never leak out
    always_comb begin
        w_attr_out = out_valid ? r_attr[r_rd_ptr] : '0;
        out_inst   = out_valid ? r_inst[r_rd_ptr] : 32'h0;
        out_pc     = out_valid ? r_pc[r_rd_ptr]   : 32'h0;
    end

    assign out_in_delay_slot = w_attr_out[4];
    assign out_is_branch     = w_attr_out[3];
    assign out_undefined     = w_attr_out[2];
    assign out_mem_type      = w_attr_out[1:0];
    assign count             = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of per-cycle vectors plus a reset/flush sequence.
module tb_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_ADDIU = 32'h2401_0001;
    localparam logic [31:0] I_LW    = 32'h8C22_0004;
    localparam logic [31:0] I_SW    = 32'hAC22_0004;
    localparam logic [31:0] I_ERET  = 32'h4200_0018;
    localparam logic [31:0] I_ILL   = 32'h7C00_0000;
    localparam logic [31:0] I_SYS   = 32'h0000_000C;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_J     = 32'h0800_0000;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic          in_ready, out_valid, out_ds, out_br, out_und;
    logic [31:0]   out_inst, out_pc;
    logic [1:0]    out_mem;
    logic [CW-1:0] count;

    logic          n_in_ready, n_out_valid, n_out_ds, n_out_br, n_out_und;
    logic [31:0]   n_out_inst, n_out_pc;
    logic [1:0]    n_out_mem;
    logic [CW-1:0] n_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .DELAY_SLOT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_in_delay_slot(out_ds), .out_is_branch(out_br), .out_undefined(out_und),
        .out_mem_type(out_mem), .count(count)
    );

    decode_queue #(.DEPTH(DEPTH), .DELAY_SLOT_EN(1'b0)) dut_nods (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_inst(n_out_inst), .out_pc(n_out_pc),
        .out_in_delay_slot(n_out_ds), .out_is_branch(n_out_br), .out_undefined(n_out_und),
        .out_mem_type(n_out_mem), .count(n_count)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        e_valid;
        int          e_count;
        logic        e_ready;
        logic [31:0] e_pc;
        logic        e_br;
        logic        e_ds;
        logic        e_und;
        logic [1:0]  e_mem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] inst,
                                logic [31:0] pc, logic ev, int ec, logic er,
                                logic [31:0] epc, logic ebr, logic eds, logic eund,
                                logic [1:0] emem);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.inst = inst; v.pc = pc;
        v.e_valid = ev; v.e_count = ec; v.e_ready = er; v.e_pc = epc;
        v.e_br = ebr; v.e_ds = eds; v.e_und = eund; v.e_mem = emem;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0;

        //         iv or fl inst     pc        v cnt rdy epc       br ds und mem
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 1, 0, I_BEQ,   32'h100, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 1, 0, I_NOP,   32'h104, 1, 1, 1, 32'h100, 1, 0, 0, 2'd0));
        vecs.push_back(mk(1, 1, 0, I_ADDIU, 32'h108, 1, 1, 1, 32'h104, 0, 1, 0, 2'd0));
        vecs.push_back(mk(0, 1, 0, I_NOP,   32'h000, 1, 1, 1, 32'h108, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 0, I_LW,    32'h200, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 0, I_SW,    32'h204, 1, 1, 1, 32'h200, 0, 0, 0, 2'd1));
        vecs.push_back(mk(1, 0, 0, I_ERET,  32'h208, 1, 2, 1, 32'h200, 0, 0, 0, 2'd1));
        vecs.push_back(mk(1, 0, 0, I_ILL,   32'h20C, 1, 3, 1, 32'h200, 0, 0, 0, 2'd1));
        vecs.push_back(mk(1, 0, 0, I_SYS,   32'h210, 1, 4, 0, 32'h200, 0, 0, 0, 2'd1));
        vecs.push_back(mk(1, 1, 0, I_SYS,   32'h210, 1, 4, 0, 32'h200, 0, 0, 0, 2'd1));
        vecs.push_back(mk(1, 1, 0, I_SYS,   32'h210, 1, 3, 1, 32'h204, 0, 0, 0, 2'd2));
        vecs.push_back(mk(1, 0, 0, I_ADDIU, 32'h214, 1, 3, 1, 32'h208, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 1, 0, I_NOP,   32'h000, 1, 4, 0, 32'h208, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 1, 0, I_NOP,   32'h000, 1, 3, 1, 32'h20C, 0, 0, 1, 2'd0));
        vecs.push_back(mk(1, 1, 0, I_NOP,   32'h218, 1, 2, 1, 32'h210, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 1, 2, 1, 32'h214, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 0, I_JR,    32'h300, 1, 2, 1, 32'h214, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 1, I_NOP,   32'h304, 1, 3, 0, 32'h214, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 0, I_ADDIU, 32'h308, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 1, 1, 1, 32'h308, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 1, 0, I_J,     32'h400, 1, 1, 1, 32'h308, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 1, 0, I_NOP,   32'h000, 1, 1, 1, 32'h400, 1, 0, 0, 2'd0));
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(1, 0, 0, I_NOP,   32'h404, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));
        vecs.push_back(mk(0, 1, 0, I_NOP,   32'h000, 1, 1, 1, 32'h404, 0, 1, 0, 2'd0));
        vecs.push_back(mk(0, 0, 0, I_NOP,   32'h000, 0, 0, 1, 32'h000, 0, 0, 0, 2'd0));

        // Two reset edges, then observe the reset cycle itself
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_count",    -1, 32'(count),     32'd0);
        chk("rst_valid",    -1, 32'(out_valid), 32'd0);
        chk("rst_in_ready", -1, 32'(in_ready),  32'd0);
        chk("rst_out_pc",   -1, out_pc,         32'h0);
        chk("rst_out_inst", -1, out_inst,       32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            in_inst   = vecs[i].inst;
            in_pc     = vecs[i].pc;
            #1;
            chk("out_valid",    i, 32'(out_valid), 32'(vecs[i].e_valid));
            chk("count",        i, 32'(count),     32'(vecs[i].e_count));
            chk("in_ready",     i, 32'(in_ready),  32'(vecs[i].e_ready));
            chk("out_pc",       i, out_pc,         vecs[i].e_pc);
            chk("is_branch",    i, 32'(out_br),    32'(vecs[i].e_br));
            chk("delay_slot",   i, 32'(out_ds),    32'(vecs[i].e_ds));
            chk("undefined",    i, 32'(out_und),   32'(vecs[i].e_und));
            chk("mem_type",     i, 32'(out_mem),   32'(vecs[i].e_mem));
            chk("nods_count",   i, 32'(n_count),   32'(vecs[i].e_count));
            chk("nods_ds",      i, 32'(n_out_ds),  32'd0);
        end

        // Reset and flush together on a non-empty queue: reset wins, queue empties
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_inst = I_NOP; in_pc = 32'h500;
        @(negedge clk);
        in_pc = 32'h504;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        #1;
        chk("seq_pre_count", 100, 32'(count),    32'd2);
        chk("seq_in_ready",  100, 32'(in_ready), 32'd0);
        chk("seq_head_pc",   100, out_pc,        32'h500);
        @(negedge clk);
        #1;
        chk("seq_post_count", 101, 32'(count),     32'd0);
        chk("seq_post_valid", 101, 32'(out_valid), 32'd0);
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        chk("seq_release_ready", 102, 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
